// File: rtl/ifc_parse_multi.sv
// rtl/ifc_parse_multi.sv - IFC command parser with per-channel enables and framed pattern streaming
module ifc_parse_multi #(
    parameter int             DW        = 16,
    parameter int             NCH       = 4,
    parameter int             NFRAME    = 4,
    parameter int             NWORD     = 3,
    parameter logic [NCH-1:0] MODE_MASK = NCH'(4'b0110)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [15:0]    hs_cmd,
    input  logic           flag_get_cmd,
    input  logic           flag_out_data,
    input  logic           flag_abort,
    output logic [NCH-1:0] ch_en,
    output logic [DW-1:0]  data_out,
    output logic           data_valid,
    output logic           frame_done,
    output logic           xfer_done,
    output logic           busy,
    output logic           cmd_err
);

    localparam int IW = (NFRAME > 1) ? $clog2(NFRAME) : 1;
    localparam int JW = (NWORD > 1) ? $clog2(NWORD) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(NFRAME - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NWORD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  i_q, i_d;
    logic [JW-1:0]  j_q, j_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [NCH-1:0] ch_en_q, ch_en_d;
    logic [DW-1:0]  data_out_q, data_out_d;
    logic           data_valid_q, data_valid_d;
    logic           frame_done_q, frame_done_d;
    logic           xfer_done_q, xfer_done_d;
    logic           busy_q, busy_d;
    logic           cmd_err_q, cmd_err_d;

    logic [7:0]     code;
    logic           code_ok;
    logic           new_en;
    logic [NCH-1:0] ch_en_upd;
    logic [3:0]     i4;
    logic [2:0]     j3;
    logic [3:0]     n4;
    logic [DW-1:0]  word;

    // Frame index nibble and low word-index bits, zero-padded when the counters are narrow
    if (IW >= 4) begin : g_i_wide
        assign i4 = i_q[3:0];
    end else begin : g_i_narrow
        assign i4 = {{(4 - IW){1'b0}}, i_q};
    end

    if (JW >= 3) begin : g_j_wide
        assign j3 = j_q[2:0];
    end else begin : g_j_narrow
        assign j3 = {{(3 - JW){1'b0}}, j_q};
    end

    // Command decode: validity and the enable the addressed channel would take
    always_comb begin
        code      = hs_cmd[15:8];
        code_ok   = (code != 8'd0) && (code <= 8'(NCH));
        new_en    = 1'b0;
        ch_en_upd = ch_en_q;
        for (int k = 0; k < NCH; k++) begin
            if (code == 8'(k + 1)) begin
                new_en       = MODE_MASK[k] ? hs_cmd[5] : 1'b1;
                ch_en_upd[k] = new_en;
            end
        end
    end

    // Pattern word for the current (cmd, frame, word) position; n = 2j-1 wraps mod 16
    always_comb begin
        n4   = {j3, 1'b0} - 4'd1;
        word = '0;
        if (j_q == '0) begin
            word[DW-1 -: 4] = i4;
            word[7:0]       = cmd_q;
        end else begin
            word[15:0] = {n4, n4, n4 + 4'd1, n4 + 4'd1};
        end
    end

    // Next-state logic: abort beats data request beats command
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        cmd_d        = cmd_q;
        ch_en_d      = ch_en_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_done_d = 1'b0;
        xfer_done_d  = 1'b0;
        cmd_err_d    = 1'b0;

        if (flag_abort) begin
            state_d = IDLE;
            i_d     = '0;
            j_d     = '0;
            cmd_d   = '0;
            ch_en_d = '0;
        end else if (flag_out_data && (state_q != IDLE)) begin
            data_out_d   = word;
            data_valid_d = 1'b1;
            cmd_err_d    = flag_get_cmd;
            state_d      = STREAM;
            if (j_q == J_LAST) begin
                j_d          = '0;
                frame_done_d = 1'b1;
                if (i_q == I_LAST) begin
                    i_d         = '0;
                    xfer_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end else begin
                j_d = j_q + JW'(1);
            end
        end else if (flag_get_cmd) begin
            if ((state_q != IDLE) || !code_ok) begin
                cmd_err_d = 1'b1;
            end else begin
                cmd_d   = code;
                ch_en_d = ch_en_upd;
                i_d     = '0;
                j_d     = '0;
                state_d = new_en ? ARMED : IDLE;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            i_q          <= '0;
            j_q          <= '0;
            cmd_q        <= '0;
            ch_en_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            xfer_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            cmd_q        <= cmd_d;
            ch_en_q      <= ch_en_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_done_q <= frame_done_d;
            xfer_done_q  <= xfer_done_d;
            busy_q       <= busy_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign ch_en      = ch_en_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_done = frame_done_q;
    assign xfer_done  = xfer_done_q;
    assign busy       = busy_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_ifc_parse_multi.sv
// tb/tb_ifc_parse_multi.sv - table-driven bench for ifc_parse_multi
module tb_ifc_parse_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] hs_cmd = '0;
    logic        gc = 1'b0;
    logic        od = 1'b0;
    logic        ab = 1'b0;

    logic [3:0]  en_a, en_b;
    logic [15:0] dout_a;
    logic [31:0] dout_b;
    logic        dv_a, fd_a, xd_a, bsy_a, err_a;
    logic        dv_b, fd_b, xd_b, bsy_b, err_b;

    always #5 clk = ~clk;

    ifc_parse_multi u_dut (
        .clk(clk), .rst_n(rst_n), .hs_cmd(hs_cmd),
        .flag_get_cmd(gc), .flag_out_data(od), .flag_abort(ab),
        .ch_en(en_a), .data_out(dout_a), .data_valid(dv_a),
        .frame_done(fd_a), .xfer_done(xd_a), .busy(bsy_a), .cmd_err(err_a)
    );

    ifc_parse_multi #(.DW(32), .NWORD(4)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .hs_cmd(hs_cmd),
        .flag_get_cmd(gc), .flag_out_data(od), .flag_abort(ab),
        .ch_en(en_b), .data_out(dout_b), .data_valid(dv_b),
        .frame_done(fd_b), .xfer_done(xd_b), .busy(bsy_b), .cmd_err(err_b)
    );

    typedef struct {
        logic        ab, od, gc;
        logic [15:0] cmd;
        logic [3:0]  en;
        logic [15:0] dout;
        logic        dv, fd, xd, bsy, err;
    } vec_t;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic void add(input logic a, input logic o, input logic g, input logic [15:0] c,
                                input logic [3:0] e, input logic [15:0] d,
                                input logic v, input logic f, input logic x,
                                input logic b, input logic r);
        vec_t t;
        t.ab = a; t.od = o; t.gc = g; t.cmd = c;
        t.en = e; t.dout = d; t.dv = v; t.fd = f; t.xd = x; t.bsy = b; t.err = r;
        vq.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [63:0] pack_a();
        return {39'd0, en_a, dout_a, dv_a, fd_a, xd_a, bsy_a, err_a};
    endfunction

    function automatic logic [63:0] pack_b();
        return {23'd0, en_b, dout_b, dv_b, fd_b, xd_b, bsy_b, err_b};
    endfunction

    logic [15:0] w;
    logic [3:0]  fn;
    logic [31:0] exp_b [5];

    initial begin
        // reset held while strobes toggle
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            hs_cmd = 16'h0100; gc = k[0]; od = ~k[0];
            @(posedge clk); #1;
            chk($sformatf("reset_a%0d", k), pack_a(), 64'd0);
            chk($sformatf("reset_b%0d", k), pack_b(), 64'd0);
        end
        @(negedge clk);
        gc = 0; od = 0; hs_cmd = '0; rst_n = 1'b1;

        // full stream on code 1
        add(0,0,0,16'h0000, 4'h0,16'h0000, 0,0,0,0,0);
        add(0,0,1,16'h0100, 4'h1,16'h0000, 0,0,0,1,0);
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 3; j++) begin
                fn = 4'(f);
                w  = (j == 0) ? {fn, 4'h0, 8'h01} : ((j == 1) ? 16'h1122 : 16'h3344);
                add(0,1,0,16'h0000, 4'h1, w, 1, j == 2, (f == 3) && (j == 2), !((f == 3) && (j == 2)), 0);
            end
        end
        add(0,0,1,16'h0100, 4'h1,16'h3344, 0,0,0,1,0);
        add(1,0,0,16'h0000, 4'h0,16'h3344, 0,0,0,0,0);
        add(0,1,0,16'h0000, 4'h0,16'h3344, 0,0,0,0,0);
        // rejected codes in IDLE
        add(0,0,1,16'h0500, 4'h0,16'h3344, 0,0,0,0,1);
        add(0,0,1,16'h0000, 4'h0,16'h3344, 0,0,0,0,1);
        // masked channel follows bit 5
        add(0,0,1,16'h0220, 4'h2,16'h3344, 0,0,0,1,0);
        add(1,0,0,16'h0000, 4'h0,16'h3344, 0,0,0,0,0);
        add(0,0,1,16'h0200, 4'h0,16'h3344, 0,0,0,0,0);
        add(0,1,0,16'h0000, 4'h0,16'h3344, 0,0,0,0,0);
        // command while busy, alone and together with a data strobe
        add(0,0,1,16'h0100, 4'h1,16'h3344, 0,0,0,1,0);
        add(0,0,1,16'h0200, 4'h1,16'h3344, 0,0,0,1,1);
        add(0,1,0,16'h0000, 4'h1,16'h0001, 1,0,0,1,0);
        add(0,1,1,16'h0400, 4'h1,16'h1122, 1,0,0,1,1);
        add(0,1,0,16'h0000, 4'h1,16'h3344, 1,1,0,1,0);
        add(0,1,0,16'h0000, 4'h1,16'h1001, 1,0,0,1,0);
        // abort beats data request; restart begins at frame 0 word 0
        add(1,1,0,16'h0000, 4'h0,16'h1001, 0,0,0,0,0);
        add(0,0,1,16'h0100, 4'h1,16'h1001, 0,0,0,1,0);
        add(0,1,0,16'h0000, 4'h1,16'h0001, 1,0,0,1,0);
        add(1,0,1,16'h0300, 4'h0,16'h0001, 0,0,0,0,0);
        add(0,0,1,16'h0100, 4'h1,16'h0001, 0,0,0,1,0);
        add(0,1,0,16'h0000, 4'h1,16'h0001, 1,0,0,1,0);
        add(0,1,0,16'h0000, 4'h1,16'h1122, 1,0,0,1,0);
        add(0,1,0,16'h0000, 4'h1,16'h3344, 1,1,0,1,0);
        add(0,1,0,16'h0000, 4'h1,16'h1001, 1,0,0,1,0);

        foreach (vq[k]) begin
            @(negedge clk);
            ab = vq[k].ab; od = vq[k].od; gc = vq[k].gc; hs_cmd = vq[k].cmd;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", k), pack_a(),
                {39'd0, vq[k].en, vq[k].dout, vq[k].dv, vq[k].fd, vq[k].xd, vq[k].bsy, vq[k].err});
        end

        // asynchronous reset during word 5, checked between clock edges
        @(negedge clk);
        ab = 0; gc = 0; hs_cmd = '0; od = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_a", pack_a(), 64'd0);
        chk("async_rst_b", pack_b(), 64'd0);
        @(posedge clk); #1;
        chk("async_hold_a", pack_a(), 64'd0);
        @(negedge clk);
        od = 0; rst_n = 1'b1;

        // wide instance: DW=32, NWORD=4
        @(negedge clk);
        gc = 1; hs_cmd = 16'h0100;
        @(posedge clk); #1;
        chk("wide_arm", {59'd0, en_b, bsy_b}, {59'd0, 4'h1, 1'b1});
        exp_b[0] = 32'h0000_0001;
        exp_b[1] = 32'h0000_1122;
        exp_b[2] = 32'h0000_3344;
        exp_b[3] = 32'h0000_5566;
        exp_b[4] = 32'h1000_0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            gc = 0; hs_cmd = '0; od = 1;
            @(posedge clk); #1;
            chk($sformatf("wide_word%0d", k), {30'd0, dout_b, dv_b, fd_b}, {30'd0, exp_b[k], 1'b1, k == 3});
        end
        @(negedge clk);
        od = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ifc_parse_multi.md
# ifc_parse_multi

Parametrised successor of the IFC command parser. It sits between the IFC handshake front end (`hs_cmd`, `flag_*` strobes) and the host-side data path. It decodes a channel command and drives per-channel enables. It then streams a framed, generated data pattern one word per `flag_out_data` strobe, with configurable frame and word counts, completion flags and error reporting.

## Interface
- `DW`, 16: data word width; must be ≥ 16.
- `NCH`, 4: number of channels; valid command codes are 1..NCH, with NCH ≤ 255.
- `NFRAME`, 4: frames per command; must be ≥ 1.
- `NWORD`, 3: words per frame; must be ≥ 2.
- `MODE_MASK`, 4'b0110 (NCH bits): bit c-1 = 1 means channel c's enable follows `hs_cmd[5]`; bit c-1 = 0 means channel c's enable is forced to 1.

Ports (single clock `clk`; reset `rst_n` is asynchronous and active-low):
- `clk`  in  1  — rising-edge clock.
- `rst_n`  in  1  — asynchronous active-low reset.
- `hs_cmd`  in  16  — handshake command; code in [15:8], enable bit in [5].
- `flag_get_cmd`  in  1  — one-cycle strobe; `hs_cmd` is valid in that cycle.
- `flag_out_data`  in  1  — one-cycle strobe requesting the next output word.
- `flag_abort`  in  1  — one-cycle strobe that cancels the current transfer.
- `ch_en`  out  NCH  — channel enables; bit c-1 corresponds to code c.
- `data_out`  out  DW  — current output word.
- `data_valid`  out  1  — 1-cycle pulse marking that `data_out` was updated.
- `frame_done`  out  1  — 1-cycle pulse with the last word of each frame.
- `xfer_done`  out  1  — 1-cycle pulse with the last word of the last frame.
- `busy`  out  1  — high in ARMED and STREAM.
- `cmd_err`  out  1  — 1-cycle pulse on a rejected command.

## Operation
- **State register:** `cs` takes values IDLE, ARMED, STREAM. There is a frame counter `i` (0..NFRAME-1) and a word counter `j` (0..NWORD-1). The latched command is `cmd[7:0]`.
- **IDLE, `flag_get_cmd` with code c in 1..NCH:**
  - Latch `cmd` = c.
  - Set `ch_en[c-1]` to `hs_cmd[5]` if `MODE_MASK[c-1]` is 1, otherwise to 1.
  - Leave all other `ch_en` bits unchanged.
  - Clear `i` and `j`.
  - Go to ARMED if the resulting enable is 1; otherwise stay in IDLE.
- **IDLE, `flag_get_cmd` with code 0 or code > NCH:** pulse `cmd_err`; change no other state.
- **IDLE, `flag_out_data`:** ignored; `data_out` holds and no pulse is generated.
- **ARMED or STREAM, `flag_out_data`:**
  - Load `data_out` with word(`cmd`, `i`, `j`) and pulse `data_valid`.
  - Then advance `j`. On `j` = NWORD-1, wrap `j` to 0, pulse `frame_done`, and advance `i`.
  - On `i` = NFRAME-1 with `j` = NWORD-1, also pulse `xfer_done`, clear the counters and go to IDLE.
  - Otherwise go to (or remain in) STREAM.
- **ARMED or STREAM, `flag_get_cmd`:** rejected; pulse `cmd_err`, and `cmd`, `ch_en` and the counters are unchanged.
- **Word pattern:**
  - Word j = 0: bits [DW-1:DW-4] = `i[3:0]`, bits [7:0] = `cmd`, all other bits 0.
  - Word j ≥ 1: bits [15:0] = {n, n, n+1, n+1} as four 4-bit nibbles with n = (2j-1) mod 16, and the n+1 nibble also taken mod 16. Bits above 15 are 0.
  - Example: cmd 1, frame 2 gives words 0x2001, 0x1122, 0x3344.
- **`flag_abort`, any state:** go to IDLE, clear `i`, `j`, `cmd` and all `ch_en`, and emit no pulses. `data_out` holds.
- **Priority within a cycle:** `flag_abort` > `flag_out_data` > `flag_get_cmd`. A `flag_get_cmd` that coincides with an accepted `flag_out_data` in ARMED or STREAM still pulses `cmd_err`. A `flag_get_cmd` that coincides with `flag_abort` is discarded silently.
- **Counter widths:** `$clog2` of NFRAME and NWORD, each with a minimum of 1 bit. The counters never exceed their maximum.

## Timing
- Reset values: `ch_en` = 0, `data_out` = 0, `data_valid` = 0, `frame_done` = 0, `xfer_done` = 0, `busy` = 0, `cmd_err` = 0, state IDLE, all counters 0.
- All outputs are registered.
- `flag_out_data` sampled on edge k produces `data_out`, `data_valid`, `frame_done` and `xfer_done` valid after edge k. This is a latency of 1 cycle.
- `flag_get_cmd` on edge k: `ch_en`, `busy` and `cmd_err` update after edge k.
- Back-to-back `flag_out_data` strobes (one every cycle) are supported at full rate.
- After `xfer_done`, `busy` is 0 from the same edge. A new `flag_get_cmd` is accepted on the very next cycle.
- An asserted `rst_n` mid-stream forces the reset values immediately, independent of `clk`.

## Test plan
- **Reset:** hold `rst_n` low while strobes are toggling → all outputs are 0; after release, state is IDLE.
- **Full stream, code 1:** `hs_cmd` = 0x0100, `flag_get_cmd`, then 12 `flag_out_data` strobes → words 0x0001,0x1122,0x3344,0x1001,…,0x3001,0x1122,0x3344. `frame_done` pulses on words 3, 6, 9 and 12. `xfer_done` pulses on word 12 only. `busy` falls with word 12.
- **Masked channel enable:** `hs_cmd` = 0x0220 → `ch_en` = 4'b0010 and `busy` = 1. Abort, then send `hs_cmd` = 0x0200 → `ch_en` = 0, state stays IDLE, and `flag_out_data` produces no `data_valid`.
- **Errors:** `hs_cmd` = 0x0500 and `hs_cmd` = 0x0000 in IDLE → `cmd_err` pulses and nothing else changes. In STREAM, `hs_cmd` = 0x0400 arriving in the same cycle as `flag_out_data` → the word is output and `cmd_err` pulses; `cmd` stays 1.
- **Abort mid-frame:** after 4 words, assert `flag_abort` together with `flag_out_data` → no `data_valid`, `ch_en` = 0, and the next code-1 stream restarts at 0x0001.
- **Async reset mid-stream, plus parameter sweep:** assert `rst_n` low at word 5 → reset values immediately. With DW=32, NWORD=4: word 3 = 0x00005566, and word 0 of frame 1 = 0x10000001.
